// File: rtl/ldpc_lambda_loader_if.sv
// Handshake and bus bundle between the LLR source, the lambda loader and the LDPC decoder.
// The master side drives samples and dec_done; the slave side is the loader.
interface ldpc_lambda_loader_if #(
   parameter int BPS          = 12,
   parameter int IN_NBITS     = 8,
   parameter int LAMBDA_NBITS = 6
);
   logic                          in_valid;
   logic                          in_ready;
   logic [IN_NBITS-1:0]           in_llr;
   logic                          lambda_valid;
   logic [BPS*LAMBDA_NBITS-1:0]   lambda;
   logic                          dec_done;
   logic                          sat_flag;
   logic                          timeout;

   modport master (
      output in_valid, in_llr, dec_done,
      input  in_ready, lambda_valid, lambda, sat_flag, timeout
   );

   modport slave (
      input  in_valid, in_llr, dec_done,
      output in_ready, lambda_valid, lambda, sat_flag, timeout
   );
endinterface

// File: rtl/ldpc_lambda_loader.sv
// Serial LLR requantiser/packer feeding ldpc_decoder; holds off the next frame until done or budget.
// Build option: LDPC_LOADER_ROUND_EN selects round half-up instead of truncation toward -inf.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_FILL  | accepting samples, packing into the shadow register
// S_ISSUE | one cycle, lambda_valid high with the freshly loaded lambda
// S_WAIT  | decoder iterating; exit on dec_done (not 1st cycle) or budget
module ldpc_lambda_loader #(
   parameter int BPS          = 12,
   parameter int IN_NBITS     = 8,
   parameter int IN_FBITS     = 4,
   parameter int LAMBDA_IBITS = 3,
   parameter int LAMBDA_FBITS = 3,
   parameter int LAMBDA_NBITS = LAMBDA_IBITS + LAMBDA_FBITS,
   parameter int MAX_ITER     = 20
) (
   input logic                 clk,
   input logic                 rst,
   ldpc_lambda_loader_if.slave bus
);

   localparam int SHIFT    = IN_FBITS - LAMBDA_FBITS;
   localparam int SLOT_W   = $clog2(BPS);
   localparam int ITER_W   = 8;
   localparam int EXT_W    = IN_NBITS + 1;
   localparam int LAMBDA_W = BPS * LAMBDA_NBITS;

`ifdef LDPC_LOADER_ROUND_EN
   localparam logic signed [EXT_W-1:0] RND =
      (SHIFT > 0) ? EXT_W'(1 << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
`else
   localparam logic signed [EXT_W-1:0] RND = '0;
`endif
   localparam logic signed [EXT_W-1:0] SAT_HI = EXT_W'((2 ** (LAMBDA_NBITS - 1)) - 1);
   localparam logic signed [EXT_W-1:0] SAT_LO = EXT_W'(-(2 ** (LAMBDA_NBITS - 1)));

   typedef enum logic [1:0] {S_FILL, S_ISSUE, S_WAIT} state_t;

   state_t                   state, state_nxt;
   logic [SLOT_W-1:0]        slot;
   logic [ITER_W-1:0]        iter;
   logic [LAMBDA_W-1:0]      shadow, shadow_nxt, lambda_q;
   logic                     sat_sticky, sat_sticky_nxt, sat_now, sat_q, lambda_valid_q;
   logic signed [EXT_W-1:0]  llr_ext, llr_rnd, llr_shift;
   logic [LAMBDA_NBITS-1:0]  lambda_now;
   logic                     in_ready, xfer, last_slot, iter_last;

   assign in_ready  = (state == S_FILL);
   assign xfer      = bus.in_valid && in_ready;
   assign last_slot = (slot == SLOT_W'(BPS - 1));
   assign iter_last = (iter == ITER_W'(MAX_ITER - 1));

   always_comb begin
      llr_ext    = {bus.in_llr[IN_NBITS-1], bus.in_llr};
      llr_rnd    = llr_ext + RND;
      llr_shift  = llr_rnd >>> SHIFT;
      sat_now    = 1'b0;
      lambda_now = llr_shift[LAMBDA_NBITS-1:0];
      if (llr_shift > SAT_HI) begin
         sat_now    = 1'b1;
         lambda_now = SAT_HI[LAMBDA_NBITS-1:0];
      end else if (llr_shift < SAT_LO) begin
         sat_now    = 1'b1;
         lambda_now = SAT_LO[LAMBDA_NBITS-1:0];
      end
   end

   // Slot 0 lands in the MSB field; the sticky flag restarts with the first sample of a frame.
   always_comb begin
      shadow_nxt = shadow;
      for (int k = 0; k < BPS; k++) begin
         if (slot == SLOT_W'(k)) begin
            shadow_nxt[(BPS-k)*LAMBDA_NBITS-1 -: LAMBDA_NBITS] = lambda_now;
         end
      end
      sat_sticky_nxt = (slot == '0) ? sat_now : (sat_sticky | sat_now);
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_FILL:  if (xfer && last_slot) state_nxt = S_ISSUE;
         S_ISSUE: state_nxt = S_WAIT;
         S_WAIT:  if ((bus.dec_done && (iter != '0)) || iter_last) state_nxt = S_FILL;
         default: state_nxt = S_FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= S_FILL;
         slot           <= '0;
         iter           <= '0;
         shadow         <= '0;
         sat_sticky     <= 1'b0;
         lambda_q       <= '0;
         sat_q          <= 1'b0;
         lambda_valid_q <= 1'b0;
      end else begin
         state          <= state_nxt;
         lambda_valid_q <= xfer && last_slot;
         if (xfer) begin
            shadow     <= shadow_nxt;
            sat_sticky <= sat_sticky_nxt;
            slot       <= last_slot ? '0 : slot + SLOT_W'(1);
            if (last_slot) begin
               lambda_q <= shadow_nxt;
               sat_q    <= sat_sticky_nxt;
            end
         end
         if (state == S_ISSUE) begin
            iter <= '0;
         end else if (state == S_WAIT) begin
            iter <= iter + ITER_W'(1);
         end
      end
   end

   // The budget exit is qualified by same-cycle dec_done so that a done on the last cycle wins.
   assign bus.timeout      = (state == S_WAIT) && iter_last && !bus.dec_done;
   assign bus.in_ready     = in_ready;
   assign bus.lambda_valid = lambda_valid_q;
   assign bus.lambda       = lambda_q;
   assign bus.sat_flag     = sat_q;

endmodule

// File: tb/tb_ldpc_lambda_loader.sv
// Self-checking bench for ldpc_lambda_loader: timestamp/queue reference model plus directed literals.
module tb_ldpc_lambda_loader;
   localparam int BPS          = 12;
   localparam int IN_NBITS     = 8;
   localparam int IN_FBITS     = 4;
   localparam int LAMBDA_FBITS = 3;
   localparam int LN           = 6;
   localparam int MAX_ITER     = 20;
   localparam int S            = IN_FBITS - LAMBDA_FBITS;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ldpc_lambda_loader_if #(.BPS(BPS), .IN_NBITS(IN_NBITS), .LAMBDA_NBITS(LN)) bus ();

   ldpc_lambda_loader #(.BPS(BPS), .IN_NBITS(IN_NBITS), .IN_FBITS(IN_FBITS),
                        .LAMBDA_FBITS(LAMBDA_FBITS), .MAX_ITER(MAX_ITER)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference requantisation: real-valued scale by 2^-S, floor (after optional half add).
   function automatic int quant_raw(input logic [7:0] x);
      int v, d;
      v = int'($signed(x));
      d = 1 << S;
`ifdef LDPC_LOADER_ROUND_EN
      if (S > 0) v = v + d / 2;
`endif
      if (v >= 0) return v / d;
      return -((-v + d - 1) / d);
   endfunction

   function automatic int clamp(input int v);
      if (v > 31) return 31;
      if (v < -32) return -32;
      return v;
   endfunction

   function automatic logic [BPS*LN-1:0] pack(input logic [7:0] s[$]);
      logic [BPS*LN-1:0] r;
      int v;
      r = '0;
      for (int k = 0; k < BPS; k++) begin
         v = clamp(quant_raw(s[k]));
         r[(BPS-k)*LN-1 -: LN] = v[LN-1:0];
      end
      return r;
   endfunction

   // Reference model: samples queue up while not busy; a full queue fixes the issue cycle,
   // and the busy window closes on dec_done (from the 2nd wait cycle) or after MAX_ITER waits.
   bit                seen = 1'b0;
   bit                m_busy = 1'b0;
   bit                m_sat = 1'b0;
   int                cyc = 0;
   int                m_issue = 0;
   int                w;
   logic [7:0]        mq[$];
   logic [BPS*LN-1:0] m_lambda = '0;
   int                lv_count = 0;
   int                to_count = 0;

   always @(negedge clk) begin
      if (seen) begin
         w = cyc - m_issue;
         chk("in_ready", bus.in_ready, !m_busy);
         chk("lambda_valid", bus.lambda_valid, m_busy && (w == 0));
         chk("timeout", bus.timeout, m_busy && (w == MAX_ITER) && !bus.dec_done);
         chk("lambda", bus.lambda, m_lambda);
         chk("sat_flag", bus.sat_flag, m_sat);
         lv_count += int'(bus.lambda_valid);
         to_count += int'(bus.timeout);
      end
      if (rst) begin
         seen     = 1'b1;
         m_busy   = 1'b0;
         mq.delete();
         m_lambda = '0;
         m_sat    = 1'b0;
      end else if (seen) begin
         if (!m_busy) begin
            if (bus.in_valid) begin
               mq.push_back(bus.in_llr);
               if (mq.size() == BPS) begin
                  m_lambda = pack(mq);
                  m_sat    = 1'b0;
                  foreach (mq[k]) if (quant_raw(mq[k]) > 31 || quant_raw(mq[k]) < -32) m_sat = 1'b1;
                  mq.delete();
                  m_busy  = 1'b1;
                  m_issue = cyc + 1;
               end
            end
         end else begin
            w = cyc - m_issue;
            if ((w >= 2 && bus.dec_done) || w == MAX_ITER) m_busy = 1'b0;
         end
      end
      cyc++;
   end

   int dd_mode = 1;  // 0: random, 1: tied high, 2: tied low
   initial begin
      bus.dec_done = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (dd_mode)
            0:       bus.dec_done = ($urandom_range(0, 7) == 0);
            1:       bus.dec_done = 1'b1;
            default: bus.dec_done = 1'b0;
         endcase
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] s, input bit gaps);
      bit got;
      int n;
      if (gaps) begin
         while ($urandom_range(0, 3) == 0) begin
            bus.in_valid = 1'b0;
            bus.in_llr   = 8'($urandom);
            step();
         end
      end
      bus.in_valid = 1'b1;
      bus.in_llr   = s;
      n = 0;
      do begin
         @(negedge clk);
         got = bus.in_ready;
         step();
         n++;
      end while (!got && n < 100);
      if (!got) begin
         tests++;
         fails++;
         $display("FAIL send_wait: in_ready absent for %0d cycles, required within 100", n);
      end
   endtask

   task automatic send_frame(input logic [7:0] f[BPS], input bit gaps);
      for (int k = 0; k < BPS; k++) send(f[k], gaps);
   endtask

   task automatic ready_low(output int n);
      n = 0;
      @(negedge clk);
      while (!bus.in_ready && n < 300) begin
         n++;
         @(negedge clk);
      end
      step();
   endtask

   initial begin
      logic [7:0] f[BPS];
      logic [7:0] fq[$];
      logic [5:0] e1, e2;
      int n, lv0, to0;

      bus.in_valid = 1'b0;
      bus.in_llr   = '0;
      rst          = 1'b1;
      repeat (3) step();
      rst = 1'b0;

      chk("model_q10", 32'(clamp(quant_raw(8'h10))), 32'(8));
      chk("model_q7f", 32'(clamp(quant_raw(8'h7F))), 32'(31));
      chk("model_q80", 32'(clamp(quant_raw(8'h80))), 32'(-32));

      @(negedge clk);
      chk("reset_lambda", bus.lambda, '0);
      chk("reset_ready", bus.in_ready, 1'b1);
      chk("reset_valid", bus.lambda_valid, 1'b0);
      step();

      // all 0x10, dec_done tied high
      dd_mode = 1;
      foreach (f[k]) f[k] = 8'h10;
      lv0 = lv_count;
      send_frame(f, 1'b0);
      bus.in_valid = 1'b0;
      ready_low(n);
      chk("tied_done_busy", n, 3);
      chk("frame1_lambda", bus.lambda, 72'h208208208208208208);
      chk("frame1_sat", bus.sat_flag, 1'b0);
      chk("frame1_pulses", lv_count - lv0, 1);

      // saturation, dec_done tied low
      dd_mode = 2;
      foreach (f[k]) f[k] = 8'h00;
      f[0] = 8'h7F;
      f[1] = 8'h80;
      to0 = to_count;
      send_frame(f, 1'b0);
      bus.in_valid = 1'b0;
      ready_low(n);
      chk("budget_busy", n, 21);
      chk("timeout_pulses", to_count - to0, 1);
      chk("sat_v1", bus.lambda[71:66], 6'h1F);
      chk("sat_v2", bus.lambda[65:60], 6'h20);
      chk("sat_flag_set", bus.sat_flag, 1'b1);

      // rounding corner
`ifdef LDPC_LOADER_ROUND_EN
      e1 = 6'h02;
      e2 = 6'h3F;
`else
      e1 = 6'h01;
      e2 = 6'h3E;
`endif
      dd_mode = 0;
      foreach (f[k]) f[k] = 8'h00;
      f[0] = 8'h03;
      f[1] = 8'hFD;
      send_frame(f, 1'b1);
      bus.in_valid = 1'b0;
      ready_low(n);
      chk("round_v1", bus.lambda[71:66], e1);
      chk("round_v2", bus.lambda[65:60], e2);
      chk("round_sat", bus.sat_flag, 1'b0);

      // mid-frame reset after 7 transfers
      lv0 = lv_count;
      for (int k = 0; k < 7; k++) send(8'h55, 1'b0);
      bus.in_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      fq.delete();
      foreach (f[k]) begin
         f[k] = 8'($urandom);
         fq.push_back(f[k]);
      end
      send_frame(f, 1'b1);
      bus.in_valid = 1'b0;
      ready_low(n);
      chk("abort_pulses", lv_count - lv0, 1);
      chk("abort_frame", bus.lambda, pack(fq));

      // randomized back-to-back frames
      for (int fr = 0; fr < 40; fr++) begin
         if (fr % 8 == 0) dd_mode = $urandom_range(0, 2);
         foreach (f[k]) begin
            case ($urandom_range(0, 5))
               0:       f[k] = 8'h7F;
               1:       f[k] = 8'h80;
               2:       f[k] = 8'($urandom_range(0, 7)) - 8'd4;
               default: f[k] = 8'($urandom);
            endcase
         end
         send_frame(f, fr[0]);
      end
      bus.in_valid = 1'b0;
      ready_low(n);
      repeat (5) step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
